// File: rtl/vector_slide_pkg.sv
// Shared definitions for the vector slide permutation unit.
// Holds the op encoding, the lane/data defaults shared with the vector unit,
// and a helper that tells which ops move data toward lane 0.
package vector_slide_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_VECTOR_LANES = 16;

    typedef enum logic [1:0] {
        SLIDEUP    = 2'b00,
        SLIDEDOWN  = 2'b01,
        SLIDE1UP   = 2'b10,
        SLIDE1DOWN = 2'b11
    } slide_op_e;

    // Down-type ops read lane i+k; up-type ops read lane i-k.
    function automatic logic is_down(input slide_op_e op);
        return (op == SLIDEDOWN) || (op == SLIDE1DOWN);
    endfunction

endpackage

// File: rtl/vector_slide_pipe_if.sv
// Operand/result bundle of the vector slide unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low, and ready never depends combinationally on the same side's
// valid.
//   master : in_valid/op/shift/vl/scalar/vec_a/vec_b/out_ready out,
//            in_ready/out_valid/vec_out/lane_wr in
//   slave  : the unit itself, directions reversed
interface vector_slide_pipe_if
    import vector_slide_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_LANES = DEF_VECTOR_LANES,
    parameter int SHIFT_WIDTH  = $clog2(VECTOR_LANES) + 1,
    parameter int VL_WIDTH     = $clog2(VECTOR_LANES) + 1
);

    logic                                 in_valid;
    logic                                 in_ready;
    logic [1:0]                           op;
    logic [SHIFT_WIDTH-1:0]               shift;
    logic [VL_WIDTH-1:0]                  vl;
    logic [DATA_WIDTH-1:0]                scalar;
    logic [VECTOR_LANES*DATA_WIDTH-1:0]   vec_a;
    logic [VECTOR_LANES*DATA_WIDTH-1:0]   vec_b;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [VECTOR_LANES*DATA_WIDTH-1:0]   vec_out;
    logic [VECTOR_LANES-1:0]              lane_wr;

    modport master (
        output in_valid, op, shift, vl, scalar, vec_a, vec_b, out_ready,
        input  in_ready, out_valid, vec_out, lane_wr
    );

    modport slave (
        input  in_valid, op, shift, vl, scalar, vec_a, vec_b, out_ready,
        output in_ready, out_valid, vec_out, lane_wr
    );

endinterface

// File: rtl/vector_shifter.sv
// Combinational lane barrel shifter with zero fill.
//   vec_in   : source lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   k        : shift amount in lanes; bits at or above log2(lanes) mean "all out"
//   dir      : 0 = up (out[i] = in[i-k]), 1 = down (out[i] = in[i+k])
//   vec_out  : shifted lanes, vacated lanes are 0
//   mask_out : 1 where the output lane received a real source lane
module vector_shifter
    import vector_slide_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_LANES = DEF_VECTOR_LANES,
    parameter int SHIFT_WIDTH  = $clog2(VECTOR_LANES) + 1
) (
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_in,
    input  logic [SHIFT_WIDTH-1:0]             k,
    input  logic                               dir,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_out,
    output logic [VECTOR_LANES-1:0]            mask_out
);

    localparam int LOG2 = $clog2(VECTOR_LANES);
    localparam int VW   = VECTOR_LANES * DATA_WIDTH;

    // Any set bit above the barrel levels shifts everything out.
    logic overflow;
    assign overflow = |k[SHIFT_WIDTH-1:LOG2];

    // Level j conditionally shifts by 2^j lanes; the all-ones lane mask
    // travels through the same levels so it marks lanes with real data.
    for (genvar j = 0; j < LOG2; j++) begin : g_lvl
        localparam int STEP = 1 << j;
        logic [VW-1:0]           d_in;
        logic [VW-1:0]           d;
        logic [VECTOR_LANES-1:0] m_in;
        logic [VECTOR_LANES-1:0] m;

        if (j == 0) begin : g_first
            assign d_in = vec_in;
            assign m_in = '1;
        end else begin : g_next
            assign d_in = g_lvl[j-1].d;
            assign m_in = g_lvl[j-1].m;
        end

        always_comb begin
            d = d_in;
            m = m_in;
            if (k[j]) begin
                if (dir) begin
                    d = d_in >> (STEP * DATA_WIDTH);
                    m = m_in >> STEP;
                end else begin
                    d = d_in << (STEP * DATA_WIDTH);
                    m = m_in << STEP;
                end
            end
        end
    end

    assign vec_out  = overflow ? '0 : g_lvl[LOG2-1].d;
    assign mask_out = overflow ? '0 : g_lvl[LOG2-1].m;

endmodule

// File: rtl/vector_slide_pipe.sv
// Two-stage handshaked vector slide unit (slide-up/down, slide1-up/down).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of vector_slide_pipe_if
//                (operands in, vec_out/lane_wr result out)
// Stage S1 captures the operands with vl clamped to the lane count; stage S2
// runs the shifter, merges scalar insert and the vl tail/head lanes from vec_b,
// and registers the result. Each op takes two edges from accept to out_valid.
module vector_slide_pipe
    import vector_slide_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_LANES = DEF_VECTOR_LANES,
    parameter int SHIFT_WIDTH  = $clog2(VECTOR_LANES) + 1,
    parameter int VL_WIDTH     = $clog2(VECTOR_LANES) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_slide_pipe_if.slave bus
);

    localparam int DW = DATA_WIDTH;
    localparam int VW = VECTOR_LANES * DATA_WIDTH;

    // S1 registers
    logic                   s1_valid;
    slide_op_e              s1_op;
    logic [SHIFT_WIDTH-1:0] s1_k;
    logic [VL_WIDTH-1:0]    s1_vl;
    logic [DW-1:0]          s1_scalar;
    logic [VW-1:0]          s1_a;
    logic [VW-1:0]          s1_b;

    // S2 (output) registers
    logic                    out_valid_q;
    logic [VW-1:0]           vec_out_q;
    logic [VECTOR_LANES-1:0] lane_wr_q;

    logic adv2;
    logic in_ready;
    logic accept;
    logic [VL_WIDTH-1:0] vl_clamped;

    assign adv2     = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid || adv2;
    assign accept   = bus.in_valid && in_ready;

    assign vl_clamped = (bus.vl > VL_WIDTH'(VECTOR_LANES)) ? VL_WIDTH'(VECTOR_LANES) : bus.vl;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.vec_out   = vec_out_q;
    assign bus.lane_wr   = lane_wr_q;

    // Slide1 ops are a one-lane slide with the vacated lane refilled by scalar.
    logic [SHIFT_WIDTH-1:0]  eff_k;
    logic                    dir;
    logic [VW-1:0]           sh_vec;
    logic [VECTOR_LANES-1:0] sh_mask;

    assign eff_k = ((s1_op == SLIDE1UP) || (s1_op == SLIDE1DOWN)) ? SHIFT_WIDTH'(1) : s1_k;
    assign dir   = is_down(s1_op);

    vector_shifter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .VECTOR_LANES (VECTOR_LANES),
        .SHIFT_WIDTH  (SHIFT_WIDTH)
    ) u_shifter (
        .vec_in   (s1_a),
        .k        (eff_k),
        .dir      (dir),
        .vec_out  (sh_vec),
        .mask_out (sh_mask)
    );

    logic [VL_WIDTH-1:0]     last_lane;
    logic [VW-1:0]           nxt_vec;
    logic [VECTOR_LANES-1:0] nxt_wr;

    assign last_lane = s1_vl - VL_WIDTH'(1);

    // Lanes at or above vl keep vec_b; so do slide-up head lanes below k,
    // which the shifter mask marks as having no source lane.
    always_comb begin
        nxt_vec = s1_b;
        nxt_wr  = '0;
        for (int i = 0; i < VECTOR_LANES; i++) begin
            if (VL_WIDTH'(i) < s1_vl) begin
                case (s1_op)
                    SLIDEUP: begin
                        if (sh_mask[i]) begin
                            nxt_vec[i*DW +: DW] = sh_vec[i*DW +: DW];
                            nxt_wr[i]           = 1'b1;
                        end
                    end
                    SLIDEDOWN: begin
                        nxt_vec[i*DW +: DW] = sh_vec[i*DW +: DW];
                        nxt_wr[i]           = 1'b1;
                    end
                    SLIDE1UP: begin
                        nxt_vec[i*DW +: DW] = (i == 0) ? s1_scalar : sh_vec[i*DW +: DW];
                        nxt_wr[i]           = 1'b1;
                    end
                    SLIDE1DOWN: begin
                        nxt_vec[i*DW +: DW] = (VL_WIDTH'(i) == last_lane) ? s1_scalar
                                                                          : sh_vec[i*DW +: DW];
                        nxt_wr[i]           = 1'b1;
                    end
                    default: begin
                        nxt_vec[i*DW +: DW] = s1_b[i*DW +: DW];
                        nxt_wr[i]           = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_op       <= SLIDEUP;
            s1_k        <= '0;
            s1_vl       <= '0;
            s1_scalar   <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            out_valid_q <= 1'b0;
            vec_out_q   <= '0;
            lane_wr_q   <= '0;
        end else begin
            // in_ready means S1 is empty or emptying, so it takes whatever is offered.
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_op     <= slide_op_e'(bus.op);
                s1_k      <= bus.shift;
                s1_vl     <= vl_clamped;
                s1_scalar <= bus.scalar;
                s1_a      <= bus.vec_a;
                s1_b      <= bus.vec_b;
            end
            if (adv2) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    vec_out_q <= nxt_vec;
                    lane_wr_q <= nxt_wr;
                end
            end
        end
    end

endmodule
